// File: rtl/coin_input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coin_input_conditioner_pkg
//  Description : Shared constants and types for the coin/button input
//                conditioner: coin values in cents, debounce state encoding,
//                channel indices and default timing parameters.
//  Revision    : 1.0  initial release
// ============================================================================
package coin_input_conditioner_pkg;

  // Default timing: 50 MHz clk / 50000 = 1 kHz debounce sample rate.
  localparam int c_tick_div_def = 50000;
  localparam int c_db_ticks_def = 10;

  // Coin values in cents.
  localparam logic [7:0] c_dime_cents   = 8'd10;
  localparam logic [7:0] c_quater_cents = 8'd25;
  localparam logic [7:0] c_dollar_cents = 8'd100;

  // Channel ordering inside the 5-bit channel vectors.
  localparam int c_idx_dime     = 0;
  localparam int c_idx_quater   = 1;
  localparam int c_idx_dollar   = 2;
  localparam int c_idx_cancel   = 3;
  localparam int c_idx_continue = 4;
  localparam int c_num_coins    = 3;
  localparam int c_num_chan     = 5;

  // Debounce FSM encoding.
  typedef enum logic [1:0] {
    DB_IDLE         = 2'd0,
    DB_PRESS_WAIT   = 2'd1,
    DB_PRESSED      = 2'd2,
    DB_RELEASE_WAIT = 2'd3
  } db_state_t;

  // Cents for a one-hot coin event vector {dollar, quater, dime}.
  function automatic logic [7:0] coin_cents(input logic [2:0] onehot);
    logic [7:0] v;
    v = 8'd0;
    if (onehot[c_idx_dime])        v = c_dime_cents;
    else if (onehot[c_idx_quater]) v = c_quater_cents;
    else if (onehot[c_idx_dollar]) v = c_dollar_cents;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/coin_input_conditioner_debounce_cell.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_cell
//  Description : Tick-sampled debounce FSM for one synchronised input.
//                IDLE -> PRESS_WAIT -> PRESSED -> RELEASE_WAIT -> IDLE.
//                The first active sample seen in IDLE counts as sample one.
//  Ports       : clk       in   system clock
//                rst_n     in   asynchronous active-low reset
//                tick      in   one-cycle sample strobe
//                sync_in   in   synchronised raw level
//                press_evt out  one-cycle pulse on PRESS_WAIT -> PRESSED
//                held      out  channel is in PRESSED or RELEASE_WAIT
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_cell
  import coin_input_conditioner_pkg::*;
#(
  parameter int DB_TICKS   = c_db_ticks_def,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sync_in,
  output logic press_evt,
  output logic held
);

  localparam int            CW       = $clog2(DB_TICKS + 1);
  localparam logic [CW-1:0] c_db_max = CW'(DB_TICKS);
  localparam logic [CW-1:0] c_one    = CW'(1);

  db_state_t     r_state;
  db_state_t     w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_active;

  assign w_active  = sync_in ^ ACTIVE_LOW;
  // Saturating increment of the stable-sample counter.
  assign w_cnt_inc = (r_cnt == c_db_max) ? r_cnt : r_cnt + c_one;
  assign held      = (r_state == DB_PRESSED) || (r_state == DB_RELEASE_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DB_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    press_evt   = 1'b0;
    if (tick) begin
      case (r_state)
        DB_IDLE: begin
          if (w_active) begin
            w_state_nxt = DB_PRESS_WAIT;
            w_cnt_nxt   = c_one;
          end
        end
        DB_PRESS_WAIT: begin
          if (!w_active) begin
            w_state_nxt = DB_IDLE;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc >= c_db_max) begin
            w_state_nxt = DB_PRESSED;
            w_cnt_nxt   = '0;
            press_evt   = 1'b1;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        DB_PRESSED: begin
          if (!w_active) begin
            w_state_nxt = DB_RELEASE_WAIT;
            w_cnt_nxt   = c_one;
          end
        end
        DB_RELEASE_WAIT: begin
          if (w_active) begin
            w_state_nxt = DB_PRESSED;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc >= c_db_max) begin
            w_state_nxt = DB_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = DB_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/coin_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : coin_input_conditioner
//  Description : Synchronises and debounces three coin switches and two
//                push-buttons, then turns debounced press events into
//                registered one-cycle coin / error / button pulses.
//  Ports       : clk            in   system clock
//                rst_n          in   asynchronous active-low reset
//                dime_raw       in   coin switch, active-high
//                quater_raw     in   coin switch, active-high
//                dollar_raw     in   coin switch, active-high
//                cancel_raw_n   in   push-button, active-low
//                continue_raw_n in   push-button, active-low
//                coin_valid     out  one accepted coin (pulse)
//                coin_value     out  cents of the accepted coin, else 0
//                coin_err       out  rejected coin event (pulse)
//                cancel_pulse   out  one pulse per cancel press
//                continue_pulse out  one pulse per continue press
//  Revision    : 1.0  initial release
// ============================================================================
module coin_input_conditioner
  import coin_input_conditioner_pkg::*;
#(
  parameter int TICK_DIV = c_tick_div_def,
  parameter int DB_TICKS = c_db_ticks_def
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dime_raw,
  input  logic       quater_raw,
  input  logic       dollar_raw,
  input  logic       cancel_raw_n,
  input  logic       continue_raw_n,
  output logic       coin_valid,
  output logic [7:0] coin_value,
  output logic       coin_err,
  output logic       cancel_pulse,
  output logic       continue_pulse
);

  localparam int            TW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] c_tick_last = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] c_tick_one  = TW'(1);
  // Idle level of each channel: coins low, buttons high.
  localparam logic [c_num_chan-1:0] c_sync_idle = 5'b11000;

  logic [1:0]            r_rst_sync;
  logic                  w_rst_n_int;
  logic [c_num_chan-1:0] w_raw;
  logic [c_num_chan-1:0] r_sync1;
  logic [c_num_chan-1:0] r_sync2;
  logic [TW-1:0]         r_tick_cnt;
  logic                  w_tick;
  logic [c_num_chan-1:0] w_evt;
  logic [c_num_chan-1:0] w_held;
  logic                  w_any_coin_held;
  logic                  w_unused_btn_held;
  logic                  w_coin_valid_nxt;
  logic                  w_coin_err_nxt;
  logic [7:0]            w_coin_value_nxt;

  // Reset for the FSMs and outputs: asserts asynchronously, releases two
  // clocks after rst_n rises. The tick counter and input synchronisers run
  // from rst_n directly so the first tick lands exactly TICK_DIV clocks
  // after release; TICK_DIV >= 3 guarantees the FSMs are out of reset by then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n_int = r_rst_sync[1];

  assign w_raw = {continue_raw_n, cancel_raw_n, dollar_raw, quater_raw, dime_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= c_sync_idle;
      r_sync2 <= c_sync_idle;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running sample-rate divider; tick is high in the wrap cycle.
  assign w_tick = (r_tick_cnt == c_tick_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + c_tick_one;
  end

  for (genvar i = 0; i < c_num_chan; i++) begin : g_chan
    debounce_cell #(
      .DB_TICKS   (DB_TICKS),
      .ACTIVE_LOW (i >= c_num_coins)
    ) u_db (
      .clk       (clk),
      .rst_n     (w_rst_n_int),
      .tick      (w_tick),
      .sync_in   (r_sync2[i]),
      .press_evt (w_evt[i]),
      .held      (w_held[i])
    );
  end

  // Only coin channels can block each other; button hold state is unused.
  assign w_any_coin_held   = |w_held[c_num_coins-1:0];
  assign w_unused_btn_held = ^w_held[c_num_chan-1:c_num_coins];

  // A lone coin event is accepted unless another coin is still down (a coin
  // never reports held in the cycle of its own press event). Any multi-coin
  // event is rejected.
  always_comb begin
    w_coin_valid_nxt = 1'b0;
    w_coin_err_nxt   = 1'b0;
    w_coin_value_nxt = 8'd0;
    case (w_evt[c_num_coins-1:0])
      3'b000: begin
      end
      3'b001, 3'b010, 3'b100: begin
        if (w_any_coin_held) begin
          w_coin_err_nxt   = 1'b1;
        end else begin
          w_coin_valid_nxt = 1'b1;
          w_coin_value_nxt = coin_cents(w_evt[c_num_coins-1:0]);
        end
      end
      default: begin
        w_coin_err_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n_int) begin
    if (!w_rst_n_int) begin
      coin_valid     <= 1'b0;
      coin_value     <= 8'd0;
      coin_err       <= 1'b0;
      cancel_pulse   <= 1'b0;
      continue_pulse <= 1'b0;
    end else begin
      coin_valid     <= w_coin_valid_nxt;
      coin_value     <= w_coin_value_nxt;
      coin_err       <= w_coin_err_nxt;
      cancel_pulse   <= w_evt[c_idx_cancel];
      continue_pulse <= w_evt[c_idx_continue];
    end
  end

endmodule
`default_nettype wire

// File: doc/coin_input_conditioner.md
COIN_INPUT_CONDITIONER -- requirements
Module: coin_input_conditioner

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, meaning clk cycles per debounce sample tick (1 kHz at 50 MHz).
REQ-002 SHALL have parameter DB_TICKS, default 10, meaning consecutive stable ticks required to accept a level change.
REQ-003 SHALL have ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- dime_raw  in  1  coin switch, active-high, asynchronous
- quater_raw  in  1  coin switch, active-high, asynchronous
- dollar_raw  in  1  coin switch, active-high, asynchronous
- cancel_raw_n  in  1  cancel push-button, active-low, asynchronous
- continue_raw_n  in  1  continue push-button, active-low, asynchronous
- coin_valid  out  1  one-cycle pulse, one accepted coin
- coin_value  out  8  cents of accepted coin (10/25/100), valid with coin_valid
- coin_err  out  1  one-cycle pulse, coin event rejected
- cancel_pulse  out  1  one-cycle pulse per cancel press
- continue_pulse  out  1  one-cycle pulse per continue press

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchroniser before any other logic.
REQ-011 A free-running tick counter SHALL count 0..TICK_DIV-1 and assert an internal one-cycle tick on wrap.
REQ-012 Each of the five channels SHALL run a debounce FSM sampled only on tick: IDLE -> PRESS_WAIT (active seen) -> PRESSED (DB_TICKS consecutive active samples) -> RELEASE_WAIT (inactive seen) -> IDLE (DB_TICKS consecutive inactive samples).
REQ-013 A single inactive sample in PRESS_WAIT SHALL return to IDLE; a single active sample in RELEASE_WAIT SHALL return to PRESSED; stable counter clears on each return.
REQ-014 Each channel SHALL emit a one-cycle press event on the clk cycle of the PRESS_WAIT -> PRESSED transition only; holding SHALL NOT retrigger.
REQ-015 Press-event-to-output latency SHALL be exactly 1 clk (registered outputs).
REQ-016 Exactly one coin press event in a cycle SHALL yield coin_valid=1 with coin_value 10 (dime), 25 (quater), 100 (dollar).
REQ-017 Two or more coin press events in the same cycle SHALL yield coin_err=1, coin_valid=0, coin_value=0.
REQ-018 A new coin press event while any other coin channel is in PRESSED or RELEASE_WAIT SHALL yield coin_err=1 and no coin_valid.
REQ-019 coin_value SHALL be 0 whenever coin_valid=0.
REQ-020 cancel_pulse and continue_pulse SHALL be independent of coin logic and of each other; simultaneous events SHALL all be reported in the same cycle.
REQ-021 Stable counters SHALL saturate at DB_TICKS; tick counter SHALL wrap to 0.

Reset
REQ-030 rst_n low SHALL asynchronously clear synchronisers to inactive level (coins 0, buttons 1), tick counter to 0, all FSMs to IDLE, stable counters to 0, all outputs to 0.
REQ-031 Reset mid-debounce SHALL discard the pending press; an input still active after release SHALL require a full DB_TICKS qualification before any event.
REQ-032 Reset release SHALL be synchronised internally so the first tick occurs exactly TICK_DIV cycles after deassertion.

Structure
REQ-040 Shared package SHALL hold coin values (10/25/100), debounce state encoding, and default TICK_DIV/DB_TICKS.
REQ-041 One sub-module debounce_cell (parameter ACTIVE_LOW, inputs clk/rst_n/tick/sync_in, output press_evt) SHALL be instantiated five times.
REQ-042 Total RTL SHALL be 120-400 lines; no latches, no derived clocks, single clk domain.

Verification (TICK_DIV=4, DB_TICKS=3 in bench)
REQ-050 dime_raw high 20 cycles -> exactly one coin_valid with coin_value=10, 1 clk after 3rd consecutive active tick; no further pulse while held.
REQ-051 quater_raw bouncing 1/0 every tick for 8 ticks then stable high -> one coin_valid, coin_value=25, only after 3 stable ticks.
REQ-052 dime_raw and dollar_raw rising same cycle, held 20 cycles -> coin_err=1 once, coin_valid never asserted.
REQ-053 cancel_raw_n and continue_raw_n low together 20 cycles -> cancel_pulse and continue_pulse both 1 in the same single cycle.
REQ-054 dollar_raw high, rst_n pulsed low after 2 active ticks, dollar_raw held -> no pulse before 3 post-reset active ticks, then coin_value=100 once.
REQ-055 Dollar held in PRESSED, dime pressed and qualified -> coin_err=1, no coin_valid; after both released 3 ticks, dime press -> coin_value=10.
